mem_burst_arbiter: RTL and testbench
====================================

// Module: mem_burst_arbiter
// PURPOSE
//  Shares the single external-memory-controller burst interface between two frame read channels (rd0, rd1)
//  and two frame write channels (wr0, wr1). Round-robin grant per burst; each client sees a private
//  burst port identical to the controller's. Sits between the frame_fifo read/write engines and the controller.
// PARAMETERS
//  MEM_DATA_BITS  32   memory data width
//  ADDR_BITS      23   burst address width
//  BUSRT_BITS     10   burst length width
//  TIMEOUT_CYC    4096 watchdog limit in mem_clk cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  mem_clk               in  1   memory controller user clock; sole clock
//  rst_n                 in  1   asynchronous, active-low reset
//  rdN_burst_req         in  1   client N read request (N=0,1); held until its first data_valid
//  rdN_burst_len         in  BUSRT_BITS  client N read length (words)
//  rdN_burst_addr        in  ADDR_BITS   client N read base address
//  rdN_burst_data_valid  out 1   controller rd_burst_data_valid, gated to granted client
//  rdN_burst_finish      out 1   controller rd_burst_finish, gated to granted client
//  wrN_burst_req/len/addr in 1/BUSRT_BITS/ADDR_BITS  client N write request, length, address
//  wrN_burst_data        in  MEM_DATA_BITS  client N write data
//  wrN_burst_data_req    out 1   controller wr_burst_data_req, gated to granted client
//  wrN_burst_finish      out 1   controller wr_burst_finish, gated to granted client
//  rd_burst_req/len/addr out 1/BUSRT_BITS/ADDR_BITS  to controller
//  rd_burst_data_valid, rd_burst_finish  in 1  from controller (read data bus bypasses this block)
//  wr_burst_req/len/addr out 1/BUSRT_BITS/ADDR_BITS  to controller
//  wr_burst_data         out MEM_DATA_BITS  muxed write data to controller
//  wr_burst_data_req, wr_burst_finish  in 1  from controller
//  grant                 out 4   one-hot current owner {wr1,wr0,rd1,rd0}; 0 when idle
//  timeout_err           out 1   sticky watchdog flag (only with ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=S_IDLE, grant=0, last=3 (rd0 wins first), all controller-side and client-side outputs 0.
//  Client index: 0=rd0 1=rd1 2=wr0 3=wr1. Search order last+1, last+2, ... mod 4; first active req wins.
//  S_IDLE: any req -> register grant and addr/len of winner, last<=winner, go S_RD/S_WR. 1 cycle req->grant.
//  S_RD/S_WR: controller req = granted client's req (combinational via registered grant); addr/len from
//    latched copy, stable for the whole burst. Client drops req on first data_valid/data_req; the arbiter
//    does not re-issue. Controller strobes are routed only to the granted client; others see 0.
//    wr_burst_data = granted writer's data, combinational mux; 0 when no writer is granted.
//    On controller finish (rd for S_RD, wr for S_WR) -> S_REL; finish pulse is forwarded in that cycle.
//  S_REL: one cycle, grant=0, controller req=0; -> S_IDLE. Guarantees one dead cycle between bursts.
//  Simultaneous requests resolve by round-robin only; a request arriving during a burst waits.
//  Finish from the non-active direction is ignored. Client dropping req before any data is not aborted;
//    the burst completes on the controller's finish.
//  Reset mid-burst returns all outputs to reset values immediately (async); controller must be reset with it.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: counter clears on grant and counts in S_RD/S_WR; reaching TIMEOUT_CYC forces
//    S_REL, drops controller req, sets timeout_err (cleared only by rst_n).
//  Not defined: no counter; timeout_err tied 0; a burst waits forever for finish.
// STRUCTURE
//  Shared package/header mem_arb_defs: state codes S_IDLE/S_RD/S_WR/S_REL, client index constants,
//    NUM_CLIENTS=4.
//  One sub-module rr_pick4: combinational 4-way round-robin picker (req[3:0], last[1:0] -> idx, valid).
// TESTING
//  rd0 only, len=256 addr=0x100 -> rd_burst_req next cycle with len 256 addr 0x100; only rd0 sees 256 valids and finish.
//  rd0,rd1,wr0,wr1 all held from reset -> grant order rd0,rd1,wr0,wr1,rd0; one idle cycle between bursts.
//  wr1 granted, wr0 data=0xA5A5A5A5, wr1 data=0x5A5A5A5A -> controller sees only 0x5A5A5A5A; wr0_burst_data_req stays 0.
//  Stray wr_burst_finish during rd0 burst -> ignored; grant held until rd_burst_finish.
//  ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no finish -> after 16 cycles grant=0, rd_burst_req=0, timeout_err=1 until rst_n.
//  rst_n low mid-burst -> all outputs 0 without a clock edge; after release rd0 has priority again.

Source files
------------

// File: rtl/mem_arb_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_arb_defs
//  Description : Shared definitions for the memory burst arbiter: FSM state
//                codes, client index constants and client count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_defs;

    localparam int NUM_CLIENTS = 4;

    // Client indices; readers occupy the low half, writers the high half
    localparam logic [1:0] C_RD0 = 2'd0;
    localparam logic [1:0] C_RD1 = 2'd1;
    localparam logic [1:0] C_WR0 = 2'd2;
    localparam logic [1:0] C_WR1 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_REL  = 2'd3
    } arb_state_t;

    // Writers are the clients with index bit 1 set
    function automatic logic is_write(input logic [1:0] idx);
        return idx[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick4
//  Description : Combinational 4-way round-robin picker. Searches from
//                last+1 upward (mod 4); the previous winner has lowest
//                priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import mem_arb_defs::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [1:0]             last,
    output logic [1:0]             idx,
    output logic                   valid
);

    logic [1:0] w_cand;

    // Walk candidates from lowest to highest priority so the highest wins
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int k = NUM_CLIENTS; k >= 1; k--) begin
            w_cand = last + 2'(k);
            if (req[w_cand]) begin
                idx   = w_cand;
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_burst_arbiter
//  Description : Round-robin arbiter sharing one memory-controller burst
//                interface between two read and two write frame clients.
//                One burst per grant, one release cycle between bursts.
//                Optional watchdog: define ARB_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_arbiter
    import mem_arb_defs::*;
#(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 23,
    parameter int BUSRT_BITS    = 10,
    parameter int TIMEOUT_CYC   = 4096
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    // read clients
    input  logic                     rd0_burst_req,
    input  logic [BUSRT_BITS-1:0]    rd0_burst_len,
    input  logic [ADDR_BITS-1:0]     rd0_burst_addr,
    output logic                     rd0_burst_data_valid,
    output logic                     rd0_burst_finish,
    input  logic                     rd1_burst_req,
    input  logic [BUSRT_BITS-1:0]    rd1_burst_len,
    input  logic [ADDR_BITS-1:0]     rd1_burst_addr,
    output logic                     rd1_burst_data_valid,
    output logic                     rd1_burst_finish,
    // write clients
    input  logic                     wr0_burst_req,
    input  logic [BUSRT_BITS-1:0]    wr0_burst_len,
    input  logic [ADDR_BITS-1:0]     wr0_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] wr0_burst_data,
    output logic                     wr0_burst_data_req,
    output logic                     wr0_burst_finish,
    input  logic                     wr1_burst_req,
    input  logic [BUSRT_BITS-1:0]    wr1_burst_len,
    input  logic [ADDR_BITS-1:0]     wr1_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] wr1_burst_data,
    output logic                     wr1_burst_data_req,
    output logic                     wr1_burst_finish,
    // controller side
    output logic                     rd_burst_req,
    output logic [BUSRT_BITS-1:0]    rd_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic                     rd_burst_data_valid,
    input  logic                     rd_burst_finish,
    output logic                     wr_burst_req,
    output logic [BUSRT_BITS-1:0]    wr_burst_len,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     wr_burst_data_req,
    input  logic                     wr_burst_finish,
    // status
    output logic [NUM_CLIENTS-1:0]   grant,
    output logic                     timeout_err
);

    arb_state_t             r_state;
    logic [NUM_CLIENTS-1:0] r_grant;
    logic [1:0]             r_last;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [BUSRT_BITS-1:0]  r_len;

    logic [NUM_CLIENTS-1:0] w_req;
    logic [1:0]             w_pick_idx;
    logic                   w_pick_valid;
    logic [ADDR_BITS-1:0]   w_sel_addr;
    logic [BUSRT_BITS-1:0]  w_sel_len;
    logic                   w_rd_active;
    logic                   w_wr_active;
    logic                   w_tmo_hit;

    assign w_req = {wr1_burst_req, wr0_burst_req, rd1_burst_req, rd0_burst_req};

    rr_pick4 u_pick (
        .req   (w_req),
        .last  (r_last),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    // Address/length of the candidate winner, captured at grant time
    always_comb begin
        w_sel_addr = rd0_burst_addr;
        w_sel_len  = rd0_burst_len;
        case (w_pick_idx)
            C_RD1:   begin w_sel_addr = rd1_burst_addr; w_sel_len = rd1_burst_len; end
            C_WR0:   begin w_sel_addr = wr0_burst_addr; w_sel_len = wr0_burst_len; end
            C_WR1:   begin w_sel_addr = wr1_burst_addr; w_sel_len = wr1_burst_len; end
            default: begin w_sel_addr = rd0_burst_addr; w_sel_len = rd0_burst_len; end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [C_TMO_W-1:0] r_tmo_cnt;
    logic               r_timeout_err;

    assign w_tmo_hit   = (w_rd_active || w_wr_active) &&
                         (r_tmo_cnt == C_TMO_W'(TIMEOUT_CYC - 1));
    assign timeout_err = r_timeout_err;

    // Watchdog: cleared while idle (i.e. at grant), counts burst cycles, sticky error
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_rd_active || w_wr_active)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else
                r_tmo_cnt <= '0;
            if (w_tmo_hit)
                r_timeout_err <= 1'b1;
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_CYC;

    assign w_tmo_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM: pick, hold for one burst, release for one cycle
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= 2'd3;
            r_addr  <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= NUM_CLIENTS'(1) << w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_addr  <= w_sel_addr;
                        r_len   <= w_sel_len;
                        r_state <= is_write(w_pick_idx) ? S_WR : S_RD;
                    end
                end
                S_RD: begin
                    if (rd_burst_finish || w_tmo_hit) begin
                        r_grant <= '0;
                        r_state <= S_REL;
                    end
                end
                S_WR: begin
                    if (wr_burst_finish || w_tmo_hit) begin
                        r_grant <= '0;
                        r_state <= S_REL;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_rd_active = (r_state == S_RD);
    assign w_wr_active = (r_state == S_WR);
    assign grant       = r_grant;

    // Controller request follows the owner's live request; addr/len from latch
    assign rd_burst_req  = w_rd_active && |(r_grant[C_RD1:C_RD0] & w_req[C_RD1:C_RD0]);
    assign rd_burst_len  = w_rd_active ? r_len  : '0;
    assign rd_burst_addr = w_rd_active ? r_addr : '0;
    assign wr_burst_req  = w_wr_active && |(r_grant[C_WR1:C_WR0] & w_req[C_WR1:C_WR0]);
    assign wr_burst_len  = w_wr_active ? r_len  : '0;
    assign wr_burst_addr = w_wr_active ? r_addr : '0;

    // Controller strobes reach only the granted client
    assign rd0_burst_data_valid = rd_burst_data_valid && w_rd_active && r_grant[C_RD0];
    assign rd0_burst_finish     = rd_burst_finish     && w_rd_active && r_grant[C_RD0];
    assign rd1_burst_data_valid = rd_burst_data_valid && w_rd_active && r_grant[C_RD1];
    assign rd1_burst_finish     = rd_burst_finish     && w_rd_active && r_grant[C_RD1];
    assign wr0_burst_data_req   = wr_burst_data_req   && w_wr_active && r_grant[C_WR0];
    assign wr0_burst_finish     = wr_burst_finish     && w_wr_active && r_grant[C_WR0];
    assign wr1_burst_data_req   = wr_burst_data_req   && w_wr_active && r_grant[C_WR1];
    assign wr1_burst_finish     = wr_burst_finish     && w_wr_active && r_grant[C_WR1];

    // Write data mux; zero when no writer owns the bus
    always_comb begin
        wr_burst_data = '0;
        if (w_wr_active && r_grant[C_WR0])
            wr_burst_data = wr0_burst_data;
        else if (w_wr_active && r_grant[C_WR1])
            wr_burst_data = wr1_burst_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_burst_arbiter
//  Description : Self-checking bench for mem_burst_arbiter with a controller
//                stub, client stubs and a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_arbiter;

    localparam int DB = 32;
    localparam int AB = 23;
    localparam int BB = 10;

    logic          mem_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic [3:0]    cl_req  = '0;
    logic [BB-1:0] cl_len  [4];
    logic [AB-1:0] cl_addr [4];
    logic [DB-1:0] cl_data [2];
    logic          rd_dv = 1'b0, rd_fin = 1'b0, wr_dr = 1'b0, wr_fin = 1'b0;

    logic          rd0_dv, rd0_fin, rd1_dv, rd1_fin, wr0_dr, wr0_fin, wr1_dr, wr1_fin;
    logic          rd_burst_req, wr_burst_req, timeout_err;
    logic [BB-1:0] rd_burst_len, wr_burst_len;
    logic [AB-1:0] rd_burst_addr, wr_burst_addr;
    logic [DB-1:0] wr_burst_data;
    logic [3:0]    grant, cl_strobe, cl_fin;

    int checks = 0;
    int errors = 0;
    int m_last = 3;

    assign cl_strobe = {wr1_dr, wr0_dr, rd1_dv, rd0_dv};
    assign cl_fin    = {wr1_fin, wr0_fin, rd1_fin, rd0_fin};

    always #5 mem_clk = ~mem_clk;

    mem_burst_arbiter #(
        .MEM_DATA_BITS(DB), .ADDR_BITS(AB), .BUSRT_BITS(BB), .TIMEOUT_CYC(16)
    ) dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .rd0_burst_req(cl_req[0]), .rd0_burst_len(cl_len[0]), .rd0_burst_addr(cl_addr[0]),
        .rd0_burst_data_valid(rd0_dv), .rd0_burst_finish(rd0_fin),
        .rd1_burst_req(cl_req[1]), .rd1_burst_len(cl_len[1]), .rd1_burst_addr(cl_addr[1]),
        .rd1_burst_data_valid(rd1_dv), .rd1_burst_finish(rd1_fin),
        .wr0_burst_req(cl_req[2]), .wr0_burst_len(cl_len[2]), .wr0_burst_addr(cl_addr[2]),
        .wr0_burst_data(cl_data[0]), .wr0_burst_data_req(wr0_dr), .wr0_burst_finish(wr0_fin),
        .wr1_burst_req(cl_req[3]), .wr1_burst_len(cl_len[3]), .wr1_burst_addr(cl_addr[3]),
        .wr1_burst_data(cl_data[1]), .wr1_burst_data_req(wr1_dr), .wr1_burst_finish(wr1_fin),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_dv), .rd_burst_finish(rd_fin),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_dr), .wr_burst_finish(wr_fin),
        .grant(grant), .timeout_err(timeout_err)
    );

    // Reference: first pending client searching last+1, last+2, ... mod 4
    function automatic int rr_model(input bit [3:0] pend, input int last);
        for (int k = 1; k <= 4; k++)
            if (pend[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_dv = 0; rd_fin = 0; wr_dr = 0; wr_fin = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        m_last = 3;
    endtask

    task automatic set_client(input int i, input int len);
        cl_len[i]  = BB'(len);
        cl_addr[i] = AB'($urandom);
        if (i >= 2) cl_data[i-2] = $urandom;
    endtask

    // Serve one burst as controller, checking ownership and routing every cycle
    task automatic run_burst(input int exp, input int len, input bit stray);
        int       n;
        int       words;
        int       seen;
        bit       dropped;
        logic     s;
        logic [3:0] oh;
        oh = 4'b0001 << exp;
        n = 0;
        while (grant == 4'b0 && n < 40) begin tick(); n++; end
        checks++;
        if (grant !== oh) begin
            $display("FAIL grant_owner: got %b want %b", grant, oh);
            errors++;
        end
        checks++;
        if (exp < 2) begin
            if ({rd_burst_req, wr_burst_req, rd_burst_len, rd_burst_addr} !==
                {1'b1, 1'b0, cl_len[exp], cl_addr[exp]}) begin
                $display("FAIL rd_ctrl_req: req=%b wreq=%b len=%0d addr=%h want len=%0d addr=%h",
                         rd_burst_req, wr_burst_req, rd_burst_len, rd_burst_addr, cl_len[exp], cl_addr[exp]);
                errors++;
            end
        end else begin
            if ({wr_burst_req, rd_burst_req, wr_burst_len, wr_burst_addr} !==
                {1'b1, 1'b0, cl_len[exp], cl_addr[exp]}) begin
                $display("FAIL wr_ctrl_req: req=%b rreq=%b len=%0d addr=%h want len=%0d addr=%h",
                         wr_burst_req, rd_burst_req, wr_burst_len, wr_burst_addr, cl_len[exp], cl_addr[exp]);
                errors++;
            end
        end
        words = 0; seen = 0; dropped = 0;
        while (words < len) begin
            s = ($urandom_range(0, 3) != 0);
            if (exp < 2) rd_dv = s; else wr_dr = s;
            if (stray && words == len / 2) begin
                if (exp < 2) wr_fin = 1'b1; else rd_fin = 1'b1;
            end
            #1;
            if (cl_strobe[exp]) seen++;
            checks++;
            if (cl_strobe !== (s ? oh : 4'b0) || cl_fin !== 4'b0 ||
                (exp >= 2 && wr_burst_data !== cl_data[exp-2])) begin
                $display("FAIL data_route: strobe=%b fin=%b wdata=%h want strobe=%b", cl_strobe, cl_fin,
                         wr_burst_data, s ? oh : 4'b0);
                errors++;
            end
            tick();
            rd_dv = 0; wr_dr = 0; rd_fin = 0; wr_fin = 0;
            if (s) begin
                words++;
                if (!dropped) begin cl_req[exp] = 1'b0; dropped = 1; end
            end
            checks++;
            if (grant !== oh) begin
                $display("FAIL grant_hold: got %b want %b", grant, oh);
                errors++;
            end
        end
        checks++;
        if (seen != len) begin
            $display("FAIL strobe_count: got %0d want %0d", seen, len);
            errors++;
        end
        if (exp < 2) rd_fin = 1'b1; else wr_fin = 1'b1;
        #1;
        checks++;
        if (cl_fin !== oh) begin
            $display("FAIL finish_route: got %b want %b", cl_fin, oh);
            errors++;
        end
        tick();
        rd_fin = 0; wr_fin = 0;
        #1;
        checks++;
        if ({grant, rd_burst_req, wr_burst_req, wr_burst_data} !== '0) begin
            $display("FAIL release: grant=%b rreq=%b wreq=%b wdata=%h want all 0",
                     grant, rd_burst_req, wr_burst_req, wr_burst_data);
            errors++;
        end
        m_last = exp;
    endtask

    task automatic test_reset();
        cl_req = '0;
        do_reset();
        checks++;
        if ({grant, rd_burst_req, wr_burst_req, rd_burst_len, rd_burst_addr, wr_burst_len,
             wr_burst_addr, wr_burst_data, cl_strobe, cl_fin, timeout_err} !== '0) begin
            $display("FAIL reset_state: grant=%b rreq=%b wreq=%b err=%b want all 0",
                     grant, rd_burst_req, wr_burst_req, timeout_err);
            errors++;
        end
    endtask

    task automatic test_single_read();
        do_reset();
        cl_len[0] = BB'(256); cl_addr[0] = AB'(32'h100);
        cl_req[0] = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0) begin
            $display("FAIL grant_latency_early: got %b want 0000", grant);
            errors++;
        end
        tick();
        checks++;
        if (grant !== 4'b0001 || rd_burst_req !== 1'b1 || rd_burst_len !== BB'(256) ||
            rd_burst_addr !== AB'(32'h100)) begin
            $display("FAIL single_read_issue: grant=%b req=%b len=%0d addr=%h want 0001 1 256 100",
                     grant, rd_burst_req, rd_burst_len, rd_burst_addr);
            errors++;
        end
        run_burst(0, 256, 0);
    endtask

    task automatic test_round_robin_all();
        for (int i = 0; i < 4; i++) set_client(i, $urandom_range(1, 6));
        rst_n = 1'b0;
        cl_req = 4'b1111;
        do_reset();
        run_burst(0, int'(cl_len[0]), 0);
        cl_req[0] = 1'b1;
        run_burst(1, int'(cl_len[1]), 0);
        run_burst(2, int'(cl_len[2]), 0);
        run_burst(3, int'(cl_len[3]), 0);
        run_burst(0, int'(cl_len[0]), 0);
    endtask

    task automatic test_wr_mux();
        cl_req = '0;
        do_reset();
        set_client(3, 4);
        cl_data[0] = 32'hA5A5A5A5;
        cl_data[1] = 32'h5A5A5A5A;
        cl_req[3] = 1'b1;
        tick();
        checks++;
        if (wr_burst_data !== 32'h5A5A5A5A || wr0_dr !== 1'b0) begin
            $display("FAIL wr_mux: data=%h wr0_dr=%b want 5a5a5a5a 0", wr_burst_data, wr0_dr);
            errors++;
        end
        run_burst(3, 4, 0);
    endtask

    task automatic test_stray_finish();
        set_client(0, 8);
        cl_req[0] = 1'b1;
        run_burst(rr_model(4'b0001, m_last), 8, 1);
    endtask

    task automatic test_random();
        bit [3:0] pend;
        int       exp;
        int       i;
        pend = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    set_client(c, $urandom_range(1, 6));
                    pend[c] = 1'b1; cl_req[c] = 1'b1;
                end
            end
            if (pend == 4'b0) begin
                i = $urandom_range(0, 3);
                set_client(i, $urandom_range(1, 6));
                pend[i] = 1'b1; cl_req[i] = 1'b1;
            end
            exp = rr_model(pend, m_last);
            run_burst(exp, int'(cl_len[exp]), $urandom_range(0, 3) == 0);
            pend[exp] = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int n;
        cl_req = '0;
        do_reset();
        set_client(1, 20);
        cl_req[1] = 1'b1;
        n = 0;
        while (grant == 4'b0 && n < 10) begin tick(); n++; end
        rd_dv = 1'b1;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, rd_burst_req, wr_burst_req, rd_burst_len, rd_burst_addr, wr_burst_data,
             cl_strobe, cl_fin} !== '0) begin
            $display("FAIL async_reset: grant=%b rreq=%b strobe=%b want all 0",
                     grant, rd_burst_req, cl_strobe);
            errors++;
        end
        rd_dv = 1'b0;
        set_client(0, 3); set_client(1, 3);
        cl_req[1:0] = 2'b11;
        tick();
        rst_n = 1'b1;
        m_last = 3;
        run_burst(rr_model(4'b0011, m_last), 3, 0);
        run_burst(rr_model(4'b0010, m_last), 3, 0);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        cl_req = '0;
        do_reset();
        set_client(0, 8);
        cl_req[0] = 1'b1;
        n = 0;
        while (grant == 4'b0 && n < 10) begin tick(); n++; end
        n = 0;
        while (grant != 4'b0 && n < 100) begin tick(); n++; end
        cl_req[0] = 1'b0;
        checks++;
        if (n != 16 || rd_burst_req !== 1'b0 || timeout_err !== 1'b1) begin
            $display("FAIL timeout_fire: cycles=%0d req=%b err=%b want 16 0 1", n, rd_burst_req, timeout_err);
            errors++;
        end
        repeat (5) tick();
        checks++;
        if (timeout_err !== 1'b1 || grant !== 4'b0) begin
            $display("FAIL timeout_sticky: err=%b grant=%b want 1 0000", timeout_err, grant);
            errors++;
        end
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin
            $display("FAIL timeout_clear: err=%b want 0", timeout_err);
            errors++;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin cl_len[i] = '0; cl_addr[i] = '0; end
        cl_data[0] = '0; cl_data[1] = '0;
        test_reset();
        test_single_read();
        test_round_robin_all();
        test_wr_mux();
        test_stray_finish();
        test_random();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
